one_hot_channel_sequencer: RTL and testbench



---
 rtl/one_hot_channel_sequencer_pkg.sv | 51 +++++
 rtl/one_hot_channel_sequencer_next_channel.sv | 46 ++++
 rtl/one_hot_channel_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_one_hot_channel_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/one_hot_channel_sequencer_pkg.sv
// ============================================================================
// Module      : one_hot_channel_sequencer_pkg
// Description : Shared types, constants and helpers for the one-hot channel
//               sequencer:
//                 - the sequencer state enum
//                 - the default channel count
//                 - a next-set-bit-above search that returns a one-hot result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package one_hot_channel_sequencer_pkg;

  localparam int NUM_CHANNELS_DEF = 8;

  // Widest mask the search helper handles. Narrower masks are zero-extended
  // by the caller.
  localparam int MAX_CHANNELS = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2,
    ST_GAP    = 2'd3
  } seq_state_t;

  // Returns the lowest set bit of 'mask' that lies strictly above the one-hot
  // 'cur', as a one-hot value. Returns zero when there is no such bit.
  // When cur == 0, every bit of the mask counts as "above", so the result is
  // the lowest set bit of the whole mask.
  function automatic logic [MAX_CHANNELS-1:0] next_set_above(
    input logic [MAX_CHANNELS-1:0] mask,
    input logic [MAX_CHANNELS-1:0] cur
  );
    logic [MAX_CHANNELS-1:0] above;
    logic [MAX_CHANNELS-1:0] cand;
    if (cur == '0) begin
      above = '1;
    end else begin
      // (cur << 1) - 1 covers cur and every bit below it.
      // For cur at the MSB this wraps to all-ones, which leaves nothing above.
      above = ~((cur << 1) - MAX_CHANNELS'(1));
    end
    cand = mask & above;
    // Isolate the lowest set bit of the candidates.
    return cand & (~cand + MAX_CHANNELS'(1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/one_hot_channel_sequencer_next_channel.sv
// ============================================================================
// Module      : one_hot_next_channel
// Description : Purely combinational channel search. From a channel mask and
//               the current one-hot channel, it produces the next enabled
//               channel strictly above the current one (one-hot), plus a
//               found flag. With current = 0 it yields the lowest enabled
//               channel. NUM_CHANNELS must not exceed MAX_CHANNELS (32).
// Ports       : mask        in  NUM_CHANNELS  enabled-channel mask
//               current     in  NUM_CHANNELS  current channel (one-hot or 0)
//               next_select out NUM_CHANNELS  next channel (one-hot or 0)
//               found       out 1             next_select is nonzero
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module one_hot_next_channel
  import one_hot_channel_sequencer_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF
) (
  input  logic [NUM_CHANNELS-1:0] mask,
  input  logic [NUM_CHANNELS-1:0] current,
  output logic [NUM_CHANNELS-1:0] next_select,
  output logic                    found
);

  logic [MAX_CHANNELS-1:0] w_mask_ext;
  logic [MAX_CHANNELS-1:0] w_cur_ext;
  logic [MAX_CHANNELS-1:0] w_next_ext;

  always_comb begin
    w_mask_ext                 = '0;
    w_cur_ext                  = '0;
    w_mask_ext[NUM_CHANNELS-1:0] = mask;
    w_cur_ext[NUM_CHANNELS-1:0]  = current;
    w_next_ext                 = next_set_above(w_mask_ext, w_cur_ext);
  end

  assign next_select = w_next_ext[NUM_CHANNELS-1:0];
  // The upper bits of the extended result are always zero, because the mask
  // is zero-extended.
  assign found       = |w_next_ext;

endmodule

`default_nettype wire

// File: rtl/one_hot_channel_sequencer.sv
// ============================================================================
// Module      : one_hot_channel_sequencer
// Description : Walks the enabled channels in ascending order.
//               - For each channel it drives a one-hot select and offers
//                 words_per_channel words under a valid/ready handshake.
//               - After the last channel it pulses frame_done.
// Config      : `define ONE_HOT_SEQ_GAP_EN inserts a GAP_CYCLES guard gap
//               between channels and after the final channel.
// Ports       : clk, rst (async, active-high)
//               start, abort, channel_enable, words_per_channel, word_ready
//               select, word_valid, word_index, busy, frame_done
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module one_hot_channel_sequencer
  import one_hot_channel_sequencer_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int COUNT_WIDTH  = 16,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CHANNELS-1:0] channel_enable,
  input  logic [COUNT_WIDTH-1:0]  words_per_channel,
  input  logic                    word_ready,
  output logic [NUM_CHANNELS-1:0] select,
  output logic                    word_valid,
  output logic [COUNT_WIDTH-1:0]  word_index,
  output logic                    busy,
  output logic                    frame_done
);

  seq_state_t              r_state, w_state_nxt;
  logic [NUM_CHANNELS-1:0] r_mask,  w_mask_nxt;
  logic [COUNT_WIDTH-1:0]  r_count, w_count_nxt;
  logic [NUM_CHANNELS-1:0] r_cur,   w_cur_nxt;
  logic [COUNT_WIDTH-1:0]  r_index, w_index_nxt;

`ifdef ONE_HOT_SEQ_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
`endif

  logic [NUM_CHANNELS-1:0] w_nc_mask;
  logic [NUM_CHANNELS-1:0] w_nc_cur;
  logic [NUM_CHANNELS-1:0] w_nc_next;
  logic                    w_nc_found;
  logic                    w_last_word;

  // A single search instance serves both purposes:
  //  - in IDLE it finds the lowest channel of the incoming mask;
  //  - otherwise it finds the channel that follows the current one
  //    within the latched mask.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_nc_mask = channel_enable;
      w_nc_cur  = '0;
    end else begin
      w_nc_mask = r_mask;
      w_nc_cur  = r_cur;
    end
  end

  one_hot_next_channel #(
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_next_channel (
    .mask        (w_nc_mask),
    .current     (w_nc_cur),
    .next_select (w_nc_next),
    .found       (w_nc_found)
  );

  assign w_last_word = (r_index == r_count - COUNT_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_mask    <= '0;
      r_count   <= '0;
      r_cur     <= '0;
      r_index   <= '0;
`ifdef ONE_HOT_SEQ_GAP_EN
      r_gap_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_mask    <= w_mask_nxt;
      r_count   <= w_count_nxt;
      r_cur     <= w_cur_nxt;
      r_index   <= w_index_nxt;
`ifdef ONE_HOT_SEQ_GAP_EN
      r_gap_cnt <= w_gap_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mask_nxt    = r_mask;
    w_count_nxt   = r_count;
    w_cur_nxt     = r_cur;
    w_index_nxt   = r_index;
`ifdef ONE_HOT_SEQ_GAP_EN
    w_gap_cnt_nxt = r_gap_cnt;
`endif

    if (abort) begin
      // Abort wins over everything and returns to the reset picture,
      // with no frame_done pulse.
      w_state_nxt   = ST_IDLE;
      w_mask_nxt    = '0;
      w_count_nxt   = '0;
      w_cur_nxt     = '0;
      w_index_nxt   = '0;
`ifdef ONE_HOT_SEQ_GAP_EN
      w_gap_cnt_nxt = '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_mask_nxt  = channel_enable;
            w_count_nxt = words_per_channel;
            w_index_nxt = '0;
            if (w_nc_found && (words_per_channel != '0)) begin
              w_cur_nxt   = w_nc_next;
              w_state_nxt = ST_STREAM;
            end else begin
              // Empty mask or zero count: finish without offering a word.
              w_cur_nxt   = '0;
              w_state_nxt = ST_DONE;
            end
          end
        end

        ST_STREAM: begin
          // word_valid is implied by this state, so word_ready alone
          // completes the handshake here.
          if (word_ready) begin
            if (!w_last_word) begin
              w_index_nxt = r_index + COUNT_WIDTH'(1);
            end else begin
              w_index_nxt = '0;
`ifdef ONE_HOT_SEQ_GAP_EN
              // r_cur stays put, so GAP can search above it on exit.
              w_state_nxt   = ST_GAP;
              w_gap_cnt_nxt = GAP_W'(GAP_CYCLES - 1);
`else
              if (w_nc_found) begin
                w_cur_nxt = w_nc_next;
              end else begin
                w_cur_nxt   = '0;
                w_state_nxt = ST_DONE;
              end
`endif
            end
          end
        end

`ifdef ONE_HOT_SEQ_GAP_EN
        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            if (w_nc_found) begin
              w_cur_nxt   = w_nc_next;
              w_state_nxt = ST_STREAM;
            end else begin
              w_cur_nxt   = '0;
              w_state_nxt = ST_DONE;
            end
          end else begin
            w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
          end
        end
`endif

        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // The select output is gated by the state, so it is zero outside STREAM
  // regardless of what r_cur holds.
  assign select     = (r_state == ST_STREAM) ? r_cur : '0;
  assign word_valid = (r_state == ST_STREAM);
  assign word_index = r_index;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_one_hot_channel_sequencer.sv
// ============================================================================
// Module      : tb_one_hot_channel_sequencer
// Description : Self-checking bench for one_hot_channel_sequencer.
//               - A frame is modelled as a queue of (channel, index)
//                 transfers, which is popped on each handshake.
//               - Directed frames are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_one_hot_channel_sequencer;

  localparam int NCH = 8;
  localparam int CW  = 16;
  localparam int GAP = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [NCH-1:0] channel_enable = '0;
  logic [CW-1:0]  words_per_channel = '0;
  logic           word_ready = 1'b0;
  logic [NCH-1:0] select;
  logic           word_valid;
  logic [CW-1:0]  word_index;
  logic           busy;
  logic           frame_done;

  one_hot_channel_sequencer #(
    .NUM_CHANNELS (NCH),
    .COUNT_WIDTH  (CW),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .channel_enable    (channel_enable),
    .words_per_channel (words_per_channel),
    .word_ready        (word_ready),
    .select            (select),
    .word_valid        (word_valid),
    .word_index        (word_index),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted start expands into the full ordered list of transfers.
  // The model tracks:
  //   - which transfer is on offer (head of the queue);
  //   - whether a guard gap is running;
  //   - whether the completion pulse is due.
  typedef struct {
    int ch;
    int idx;
  } xfer_t;

  xfer_t q[$];
  bit    m_active;
  bit    m_done;
  int    m_gap;

  function automatic bit m_valid();
    return m_active && !m_done && (m_gap == 0) && (q.size() > 0);
  endfunction

  task automatic model_reset();
    q.delete();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_gap    = 0;
  endtask

  task automatic model_step();
    xfer_t h;
    if (abort) begin
      model_reset();
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        q.delete();
        for (int c = 0; c < NCH; c++) begin
          if (channel_enable[c]) begin
            for (int i = 0; i < int'(words_per_channel); i++) begin
              q.push_back('{c, i});
            end
          end
        end
        if (q.size() == 0) m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done   = 1'b0;
      m_active = 1'b0;
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0 && q.size() == 0) m_done = 1'b1;
    end else if (word_ready) begin
      h = q.pop_front();
`ifdef ONE_HOT_SEQ_GAP_EN
      if (q.size() == 0 || q[0].ch != h.ch) m_gap = GAP;
`else
      if (q.size() == 0) m_done = 1'b1;
`endif
    end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] es;
    bit             ev;
    es = '0;
    ev = m_valid();
    if (ev) es[q[0].ch] = 1'b1;
    check("select", 32'(select), 32'(es));
    check("word_valid", 32'(word_valid), 32'(ev));
    if (ev) check("word_index", 32'(word_index), 32'(q[0].idx));
    check("busy", 32'(busy), 32'(m_active));
    check("frame_done", 32'(frame_done), 32'(m_done));
  endtask

  // One clock cycle:
  //   1. check the outputs;
  //   2. apply this cycle's inputs;
  //   3. advance the model;
  //   4. wait for the next negedge.
  task automatic step(input bit s, input bit a, input logic [NCH-1:0] m,
                      input logic [CW-1:0] c, input bit r);
    check_outputs();
    start             = s;
    abort             = a;
    channel_enable    = m;
    words_per_channel = c;
    word_ready        = r;
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n, input bit r);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, NCH'($urandom), CW'($urandom_range(0, 7)), r);
    end
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_select", 32'(select), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_valid", 32'(word_valid), 32'h0);
    check("reset_index", 32'(word_index), 32'h0);
    check("reset_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Frame over channels 0, 2 and 7 with three words each and no stalls.
    step(1'b1, 1'b0, 8'b1000_0101, 16'd3, 1'b1);
    idle_steps(14 + 3 * GAP, 1'b1);

    // Backpressure on a single channel.
    step(1'b1, 1'b0, 8'b0000_0010, 16'd2, 1'b0);
    idle_steps(5, 1'b0);
    idle_steps(6 + 2 * GAP, 1'b1);

    // Degenerate start: an empty mask completes at once.
    step(1'b1, 1'b0, 8'h00, 16'd5, 1'b1);
    idle_steps(3, 1'b1);

    // Only the top channel enabled, one word per channel.
    step(1'b1, 1'b0, 8'h80, 16'd1, 1'b1);
    idle_steps(4 + GAP, 1'b1);

    // Abort in the middle of the frame.
    step(1'b1, 1'b0, 8'b0000_1010, 16'd3, 1'b1);
    idle_steps(4, 1'b1);
    step(1'b0, 1'b1, 8'hFF, 16'd3, 1'b1);
    idle_steps(3, 1'b1);

    // Asynchronous reset in the middle of the frame.
    step(1'b1, 1'b0, 8'b0000_1010, 16'd3, 1'b1);
    idle_steps(2, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_select", 32'(select), 32'h0);
    check("arst_valid", 32'(word_valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_index", 32'(word_index), 32'h0);
    check("arst_done", 32'(frame_done), 32'h0);
    model_reset();
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_steps(2, 1'b1);

    // A start while busy must not disturb the frame in flight.
    step(1'b1, 1'b0, 8'b1000_0001, 16'd2, 1'b1);
    step(1'b1, 1'b0, 8'hFF, 16'd4, 1'b1);
    step(1'b1, 1'b0, 8'h3C, 16'd1, 1'b1);
    idle_steps(6 + 2 * GAP, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [NCH-1:0] m;
      m = NCH'($urandom);
      if ($urandom_range(0, 7) == 0) m = '0;
      step($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0, m,
           CW'($urandom_range(0, 4)), $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
